// File: rtl/sysid_check_pkg.sv
// rtl/sysid_check_pkg.sv - shared FSM encoding, register offsets and counter sizing
package sysid_check_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ID_REQ  = 3'd1,
      ST_ID_WAIT = 3'd2,
      ST_TS_REQ  = 3'd3,
      ST_TS_WAIT = 3'd4,
      ST_DONE    = 3'd5
   } sysid_state_e;

   localparam int unsigned ID_OFFSET = 0;
   localparam int unsigned TS_OFFSET = 4;

   // Never narrower than 8 bits so small timeouts still get a sane counter.
   function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
      int unsigned w;
      w = $clog2(cycles + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/sysid_read_port.sv
// rtl/sysid_read_port.sv - single Avalon-MM read handshake with per-read timeout
module sysid_read_port
   import sysid_check_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  launch_i,
   input  logic                  req_i,
   input  logic                  pend_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   output logic [ADDR_WIDTH-1:0] avm_address,
   output logic                  avm_read,
   input  logic [31:0]           avm_readdata,
   input  logic                  avm_waitrequest,
   input  logic                  avm_readdatavalid,
   output logic                  accept_o,
   output logic                  rvalid_o,
   output logic                  tmo_o,
   output logic [31:0]           rdata_o
);

   localparam int unsigned     CW       = tmo_cnt_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          active;

   // Data only counts in the wait phase, or in the accept cycle of a zero-latency slave.
   always_comb begin
      active      = req_i | pend_i;
      avm_read    = req_i;
      avm_address = addr_i;
      accept_o    = req_i & ~avm_waitrequest;
      rvalid_o    = avm_readdatavalid & (pend_i | accept_o);
      rdata_o     = avm_readdata;
      tmo_o       = active & (cnt_q >= CNT_LAST) & ~rvalid_o;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (launch_i) begin
         cnt_d = '0;
      end else if (active && (cnt_q < CNT_LAST)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sysid_check_master.sv
// rtl/sysid_check_master.sv - reads sysid ID and timestamp words and reports a pass/fail verdict
module sysid_check_master
   import sysid_check_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH         = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR          = '0,
   parameter logic [31:0]           EXPECTED_ID        = 32'd31,
   parameter logic [31:0]           EXPECTED_TIMESTAMP = 32'd1718188374,
   parameter int unsigned           TIMEOUT_CYCLES     = 255,
   parameter bit                    AUTO_START         = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] avm_address,
   output logic                  avm_read,
   input  logic [31:0]           avm_readdata,
   input  logic                  avm_waitrequest,
   input  logic                  avm_readdatavalid,
   output logic                  busy,
   output logic                  done,
   output logic                  id_ok,
   output logic                  ts_ok,
   output logic                  pass,
   output logic                  timeout_err,
   output logic [31:0]           id_value,
   output logic [31:0]           ts_value
);

   sysid_state_e state_q, state_d;

   logic        auto_q, auto_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        pass_q, pass_d;
   logic        tmo_err_q, tmo_err_d;
   logic [31:0] id_value_q, id_value_d;
   logic [31:0] ts_value_q, ts_value_d;

   logic                  go;
   logic                  launch;
   logic                  port_req;
   logic                  port_pend;
   logic [ADDR_WIDTH-1:0] port_addr;
   logic                  port_accept;
   logic                  port_rvalid;
   logic                  port_tmo;
   logic [31:0]           port_rdata;

   sysid_read_port #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_read_port (
      .clock             (clock),
      .reset_n           (reset_n),
      .launch_i          (launch),
      .req_i             (port_req),
      .pend_i            (port_pend),
      .addr_i            (port_addr),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_readdata      (avm_readdata),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdatavalid (avm_readdatavalid),
      .accept_o          (port_accept),
      .rvalid_o          (port_rvalid),
      .tmo_o             (port_tmo),
      .rdata_o           (port_rdata)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (go) state_d = ST_ID_REQ;
         ST_ID_REQ: begin
            if (port_tmo)         state_d = ST_DONE;
            else if (port_rvalid) state_d = ST_TS_REQ;
            else if (port_accept) state_d = ST_ID_WAIT;
         end
         ST_ID_WAIT: begin
            if (port_tmo)         state_d = ST_DONE;
            else if (port_rvalid) state_d = ST_TS_REQ;
         end
         ST_TS_REQ: begin
            if (port_tmo)         state_d = ST_DONE;
            else if (port_rvalid) state_d = ST_DONE;
            else if (port_accept) state_d = ST_TS_WAIT;
         end
         ST_TS_WAIT: begin
            if (port_tmo || port_rvalid) state_d = ST_DONE;
         end
         ST_DONE:    if (go) state_d = ST_ID_REQ;
         default:    state_d = ST_IDLE;
      endcase
      // The timeout counter restarts whenever a request phase is entered.
      launch = ((state_d == ST_ID_REQ) && (state_q != ST_ID_REQ)) ||
               ((state_d == ST_TS_REQ) && (state_q != ST_TS_REQ));
   end

   always_comb begin
      go        = ((state_q == ST_IDLE) && (start || auto_q)) ||
                  ((state_q == ST_DONE) && start);
      port_req  = (state_q == ST_ID_REQ) || (state_q == ST_TS_REQ);
      port_pend = (state_q == ST_ID_WAIT) || (state_q == ST_TS_WAIT);
      if ((state_q == ST_TS_REQ) || (state_q == ST_TS_WAIT)) begin
         port_addr = BASE_ADDR + ADDR_WIDTH'(TS_OFFSET);
      end else begin
         port_addr = BASE_ADDR + ADDR_WIDTH'(ID_OFFSET);
      end
   end

   always_comb begin
      auto_d     = 1'b0;
      busy_d     = busy_q;
      done_d     = done_q;
      id_ok_d    = id_ok_q;
      ts_ok_d    = ts_ok_q;
      pass_d     = pass_q;
      tmo_err_d  = tmo_err_q;
      id_value_d = id_value_q;
      ts_value_d = ts_value_q;
      if (go) begin
         busy_d     = 1'b1;
         done_d     = 1'b0;
         id_ok_d    = 1'b0;
         ts_ok_d    = 1'b0;
         pass_d     = 1'b0;
         tmo_err_d  = 1'b0;
         id_value_d = '0;
         ts_value_d = '0;
      end else begin
         case (state_q)
            ST_ID_REQ, ST_ID_WAIT: begin
               if (port_tmo) begin
                  tmo_err_d = 1'b1;
               end else if (port_rvalid) begin
                  id_value_d = port_rdata;
                  id_ok_d    = (port_rdata == EXPECTED_ID);
               end
            end
            ST_TS_REQ, ST_TS_WAIT: begin
               if (port_tmo) begin
                  tmo_err_d = 1'b1;
               end else if (port_rvalid) begin
                  ts_value_d = port_rdata;
                  ts_ok_d    = (port_rdata == EXPECTED_TIMESTAMP);
               end
            end
            ST_DONE: begin
               done_d = 1'b1;
               busy_d = 1'b0;
               pass_d = id_ok_q & ts_ok_q & ~tmo_err_q;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         auto_q     <= AUTO_START;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         id_ok_q    <= 1'b0;
         ts_ok_q    <= 1'b0;
         pass_q     <= 1'b0;
         tmo_err_q  <= 1'b0;
         id_value_q <= '0;
         ts_value_q <= '0;
      end else begin
         auto_q     <= auto_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         id_ok_q    <= id_ok_d;
         ts_ok_q    <= ts_ok_d;
         pass_q     <= pass_d;
         tmo_err_q  <= tmo_err_d;
         id_value_q <= id_value_d;
         ts_value_q <= ts_value_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign pass        = pass_q;
   assign timeout_err = tmo_err_q;
   assign id_value    = id_value_q;
   assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// tb/tb_sysid_check_master.sv - randomized self-checking bench with a behavioural Avalon slave
module tb_sysid_check_master;

   localparam logic [31:0] EXP_ID = 32'd31;
   localparam logic [31:0] EXP_TS = 32'd1718188374;
   localparam int          TMO    = 16;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic        avm_readdatavalid;
   logic        busy, done, id_ok, ts_ok, pass, timeout_err;
   logic [31:0] id_value, ts_value;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] cfg_id = EXP_ID;
   logic [31:0] cfg_ts = EXP_TS;
   int          cfg_lat = 1;
   int          cfg_stall = 0;
   bit          cfg_respond = 1'b1;
   bit          cfg_noise = 1'b0;
   logic [31:0] acc_log[$];
   int          stall_viol = 0;

   always #5 clock = ~clock;

   sysid_check_master #(
      .ADDR_WIDTH         (32),
      .BASE_ADDR          (32'd0),
      .EXPECTED_ID        (EXP_ID),
      .EXPECTED_TIMESTAMP (EXP_TS),
      .TIMEOUT_CYCLES     (TMO),
      .AUTO_START         (1'b1)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .start             (start),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_readdata      (avm_readdata),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdatavalid (avm_readdatavalid),
      .busy              (busy),
      .done              (done),
      .id_ok             (id_ok),
      .ts_ok             (ts_ok),
      .pass              (pass),
      .timeout_err       (timeout_err),
      .id_value          (id_value),
      .ts_value          (ts_value)
   );

   // Behavioural slave: decides each cycle's response on the falling edge.
   initial begin : slave
      int          stall_left;
      bit          pend_v;
      logic [31:0] pend_d;
      bit          prev_stalled;
      logic [31:0] prev_addr;
      logic [31:0] word;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      stall_left = 0; pend_v = 1'b0; pend_d = '0; prev_stalled = 1'b0; prev_addr = '0;
      forever begin
         @(negedge clock);
         avm_readdatavalid = 1'b0;
         avm_readdata      = $urandom;
         if (pend_v) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend_d;
            pend_v            = 1'b0;
         end
         if (avm_read) begin
            if (prev_stalled && (avm_address !== prev_addr)) stall_viol++;
            if (stall_left > 0) begin
               avm_waitrequest = 1'b1;
               stall_left--;
            end else begin
               avm_waitrequest = 1'b0;
               stall_left = cfg_stall;
               acc_log.push_back(avm_address);
               word = (avm_address == 32'd4) ? cfg_ts : cfg_id;
               if (cfg_respond) begin
                  if (cfg_lat == 0) begin
                     avm_readdatavalid = 1'b1;
                     avm_readdata      = word;
                  end else begin
                     pend_v = 1'b1;
                     pend_d = word;
                  end
               end
            end
         end else begin
            if (prev_stalled) stall_viol++;
            avm_waitrequest = 1'b0;
            stall_left = cfg_stall;
            if (cfg_noise && !avm_readdatavalid) begin
               avm_readdatavalid = 1'b1;
            end
         end
         prev_stalled = avm_read && avm_waitrequest;
         prev_addr    = avm_address;
      end
   end

   function automatic int exp_done_edges(input int lat, input int stall);
      return 2 * (stall + 1 + lat) + 1;
   endfunction

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int max_edges, output int edges);
      edges = -1;
      for (int k = 1; k <= max_edges; k++) begin
         @(posedge clock);
         #1;
         if (done) begin
            edges = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_cmp++;
      if ({busy, done, id_ok, ts_ok, pass, timeout_err, avm_read} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 0000000", {busy, done, id_ok, ts_ok, pass, timeout_err, avm_read});
      end
      n_cmp++;
      if ({id_value, ts_value, avm_address} !== 96'd0) begin
         n_bad++;
         $display("FAIL reset_values: id=%0d ts=%0d addr=%0d want all 0", id_value, ts_value, avm_address);
      end
   endtask

   task automatic test_nominal_auto();
      int e;
      cfg_id = EXP_ID; cfg_ts = EXP_TS; cfg_lat = 1; cfg_stall = 0;
      acc_log.delete();
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL auto_busy: got %b want 1", busy);
      end
      wait_done(40, e);
      n_cmp++;
      if (e != 5) begin
         n_bad++;
         $display("FAIL auto_latency: got %0d want 5", e);
      end
      n_cmp++;
      if ({id_value, ts_value} !== {EXP_ID, EXP_TS} || {id_ok, ts_ok, pass, timeout_err, busy} !== 5'b11100) begin
         n_bad++;
         $display("FAIL auto_result: id=%0d ts=%0d flags=%b want 31 %0d 11100", id_value, ts_value, {id_ok, ts_ok, pass, timeout_err, busy}, EXP_TS);
      end
   endtask

   // Directed rows first (ID mismatch, 3-cycle stall, zero latency), then random patterns.
   task automatic test_patterns();
      int          e, r;
      bit          x_id, x_ts;
      for (int i = 0; i < 12; i++) begin
         if (i == 0) begin
            cfg_id = 32'd30; cfg_ts = EXP_TS; cfg_lat = 1; cfg_stall = 0;
         end else if (i == 1) begin
            cfg_id = EXP_ID; cfg_ts = EXP_TS; cfg_lat = 1; cfg_stall = 3;
         end else if (i == 2) begin
            cfg_id = EXP_ID; cfg_ts = EXP_TS; cfg_lat = 0; cfg_stall = 0;
         end else begin
            r = $urandom_range(0, 2);
            cfg_id = (r == 0) ? EXP_ID : (r == 1) ? 32'd30 : $urandom;
            cfg_ts = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
            cfg_lat = $urandom_range(0, 1);
            cfg_stall = $urandom_range(0, 4);
         end
         x_id = (cfg_id == EXP_ID);
         x_ts = (cfg_ts == EXP_TS);
         acc_log.delete();
         stall_viol = 0;
         pulse_start();
         n_cmp++;
         if ({done, busy, id_ok, ts_ok, pass, timeout_err} !== 6'b010000 || {id_value, ts_value} !== 64'd0) begin
            n_bad++;
            $display("FAIL restart_clear[%0d]: flags=%b id=%0d ts=%0d want 010000 0 0", i, {done, busy, id_ok, ts_ok, pass, timeout_err}, id_value, ts_value);
         end
         wait_done(60, e);
         n_cmp++;
         if (e != exp_done_edges(cfg_lat, cfg_stall)) begin
            n_bad++;
            $display("FAIL done_latency[%0d]: got %0d want %0d (lat=%0d stall=%0d)", i, e, exp_done_edges(cfg_lat, cfg_stall), cfg_lat, cfg_stall);
         end
         n_cmp++;
         if (id_value !== cfg_id || ts_value !== cfg_ts) begin
            n_bad++;
            $display("FAIL captured[%0d]: id=%h ts=%h want %h %h", i, id_value, ts_value, cfg_id, cfg_ts);
         end
         n_cmp++;
         if ({id_ok, ts_ok, pass, timeout_err, busy} !== {x_id, x_ts, x_id & x_ts, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL verdict[%0d]: got %b want %b", i, {id_ok, ts_ok, pass, timeout_err, busy}, {x_id, x_ts, x_id & x_ts, 2'b00});
         end
         n_cmp++;
         if (acc_log.size() != 2 || acc_log[0] !== 32'd0 || acc_log[1] !== 32'd4 || stall_viol != 0) begin
            n_bad++;
            $display("FAIL bus_reads[%0d]: reads=%0d stall_violations=%0d want 2 reads at 0,4 and 0 violations", i, acc_log.size(), stall_viol);
         end
      end
   endtask

   task automatic test_busy_start();
      int e;
      cfg_id = EXP_ID; cfg_ts = EXP_TS; cfg_lat = 1; cfg_stall = 1;
      acc_log.delete();
      pulse_start();
      @(posedge clock);
      pulse_start();
      wait_done(40, e);
      n_cmp++;
      if (e != exp_done_edges(1, 1) - 2 || acc_log.size() != 2 || pass !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_start_ignored: edges=%0d reads=%0d pass=%b want %0d 2 1", e, acc_log.size(), pass, exp_done_edges(1, 1) - 2);
      end
   endtask

   task automatic test_spurious_rdv();
      cfg_noise = 1'b1;
      repeat (6) @(posedge clock);
      #1;
      cfg_noise = 1'b0;
      n_cmp++;
      if ({done, busy, pass, avm_read} !== 4'b1010 || id_value !== EXP_ID || ts_value !== EXP_TS) begin
         n_bad++;
         $display("FAIL spurious_rdv: flags=%b id=%0d ts=%0d want 1010 31 %0d", {done, busy, pass, avm_read}, id_value, ts_value, EXP_TS);
      end
   endtask

   task automatic test_timeout();
      int te, rd;
      for (int mode = 0; mode < 2; mode++) begin
         cfg_respond = 1'b0;
         cfg_stall = (mode == 1) ? 1000 : 0;
         acc_log.delete();
         pulse_start();
         rd = int'(avm_read);
         te = -1;
         for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (timeout_err) begin
               te = k;
               break;
            end
            rd += int'(avm_read);
         end
         n_cmp++;
         if (te != TMO || avm_read !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_edge[%0d]: edge=%0d avm_read=%b want %0d 0", mode, te, avm_read, TMO);
         end
         n_cmp++;
         if (rd != ((mode == 1) ? TMO : 1) || acc_log.size() != 1 - mode) begin
            n_bad++;
            $display("FAIL timeout_bus[%0d]: read_cycles=%0d accepted=%0d want %0d %0d", mode, rd, acc_log.size(), (mode == 1) ? TMO : 1, 1 - mode);
         end
         @(posedge clock);
         #1;
         n_cmp++;
         if ({done, busy, id_ok, ts_ok, pass, timeout_err} !== 6'b100001) begin
            n_bad++;
            $display("FAIL timeout_result[%0d]: got %b want 100001", mode, {done, busy, id_ok, ts_ok, pass, timeout_err});
         end
      end
      cfg_respond = 1'b1;
      cfg_stall = 0;
   endtask

   task automatic test_reset_mid();
      int e;
      cfg_id = EXP_ID; cfg_ts = EXP_TS; cfg_lat = 1; cfg_stall = 0;
      pulse_start();
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      n_cmp++;
      if ({busy, done, id_ok, ts_ok, pass, timeout_err, avm_read} !== 7'b0 || {id_value, ts_value, avm_address} !== 96'd0) begin
         n_bad++;
         $display("FAIL reset_mid: flags=%b id=%0d ts=%0d addr=%0d want all 0", {busy, done, id_ok, ts_ok, pass, timeout_err, avm_read}, id_value, ts_value, avm_address);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      wait_done(40, e);
      n_cmp++;
      if (e != 5 || pass !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_mid_autostart: edges=%0d pass=%b want 5 1", e, pass);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_nominal_auto();
      test_patterns();
      test_busy_start();
      test_spurious_rdv();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
